// File: rtl/traffic_merger.sv
// traffic_merger: merges two packet+metadata channels into one stream with packet-atomic
// arbitration (round-robin, or strict channel-1 priority when PRIO_CH1 = 1).
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in{0,1}_pkt_{data,valid,sop,eop,empty}_i / in{0,1}_pkt_ready_o   input packet streams
//   in{0,1}_meta_{data,valid}_i / in{0,1}_meta_ready_o               input metadata (pop)
//   out_pkt_{data,valid,sop,eop,empty}_o                             merged packet stream
//   out_pkt_almost_full_i, out_meta_almost_full_i                    downstream backpressure
//   out_meta_{data,valid}_o                                          merged metadata
//   out_src_channel_o                source channel of the current output flit
//   proto_err_o                      sticky: sop seen on a non-first flit
//   stat_pkt_cnt{0,1}_o              per-channel forwarded packet counts
//
// Metadata is carried as a packed vector of META_WIDTH bits (the packed metadata_t).
// Optional feature macro: TRAFFIC_MERGER_STATS_EN enables the packet counters; without it
// the counter outputs are tied to zero.
module traffic_merger #(
  parameter int unsigned PRIO_CH1   = 0,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned META_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [511:0]          in0_pkt_data_i,
  input  logic                  in0_pkt_valid_i,
  input  logic                  in0_pkt_sop_i,
  input  logic                  in0_pkt_eop_i,
  input  logic [5:0]            in0_pkt_empty_i,
  output logic                  in0_pkt_ready_o,
  input  logic [META_WIDTH-1:0] in0_meta_data_i,
  input  logic                  in0_meta_valid_i,
  output logic                  in0_meta_ready_o,
  input  logic [511:0]          in1_pkt_data_i,
  input  logic                  in1_pkt_valid_i,
  input  logic                  in1_pkt_sop_i,
  input  logic                  in1_pkt_eop_i,
  input  logic [5:0]            in1_pkt_empty_i,
  output logic                  in1_pkt_ready_o,
  input  logic [META_WIDTH-1:0] in1_meta_data_i,
  input  logic                  in1_meta_valid_i,
  output logic                  in1_meta_ready_o,
  output logic [511:0]          out_pkt_data_o,
  output logic                  out_pkt_valid_o,
  output logic                  out_pkt_sop_o,
  output logic                  out_pkt_eop_o,
  output logic [5:0]            out_pkt_empty_o,
  input  logic                  out_pkt_almost_full_i,
  output logic [META_WIDTH-1:0] out_meta_data_o,
  output logic                  out_meta_valid_o,
  input  logic                  out_meta_almost_full_i,
  output logic                  out_src_channel_o,
  output logic                  proto_err_o,
  output logic [CNT_WIDTH-1:0]  stat_pkt_cnt0_o,
  output logic [CNT_WIDTH-1:0]  stat_pkt_cnt1_o
);

  typedef enum logic [1:0] {StIdle, StCh0, StCh1} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   first_q, first_d;   // next accepted flit is the first of the packet
  logic   proto_err_q, proto_err_d;
  logic   out_valid_q, out_meta_valid_q, out_src_q;

  logic [511:0]          out_data_q;
  logic                  out_sop_q, out_eop_q;
  logic [5:0]            out_empty_q;
  logic [META_WIDTH-1:0] out_meta_q;

  logic naf, elig0, elig1, ch_sel, acc, acc_eop;
  logic sel_valid, sel_sop, sel_eop;

  assign naf   = !out_pkt_almost_full_i && !out_meta_almost_full_i;
  assign elig0 = naf && in0_meta_valid_i && in0_pkt_valid_i && in0_pkt_sop_i;
  assign elig1 = naf && in1_meta_valid_i && in1_pkt_valid_i && in1_pkt_sop_i;

  assign ch_sel    = (state_q == StCh1);
  assign sel_valid = ch_sel ? in1_pkt_valid_i : in0_pkt_valid_i;
  assign sel_sop   = ch_sel ? in1_pkt_sop_i   : in0_pkt_sop_i;
  assign sel_eop   = ch_sel ? in1_pkt_eop_i   : in0_pkt_eop_i;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    first_d          = first_q;
    in0_pkt_ready_o  = 1'b0;
    in1_pkt_ready_o  = 1'b0;
    in0_meta_ready_o = 1'b0;
    in1_meta_ready_o = 1'b0;
    acc              = 1'b0;
    acc_eop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Grant costs a cycle: no channel is ready while idle.
        first_d = 1'b1;
        if (elig0 && elig1) begin
          if ((PRIO_CH1 != 0) || !last_grant_q) state_d = StCh1;
          else                                  state_d = StCh0;
        end else if (elig0) begin
          state_d = StCh0;
        end else if (elig1) begin
          state_d = StCh1;
        end
      end
      StCh0, StCh1: begin
        if (ch_sel) in1_pkt_ready_o = !out_pkt_almost_full_i;
        else        in0_pkt_ready_o = !out_pkt_almost_full_i;
        acc     = sel_valid && !out_pkt_almost_full_i;
        acc_eop = acc && sel_eop;
        if (acc) first_d = 1'b0;
        if (acc_eop) begin
          if (ch_sel) in1_meta_ready_o = 1'b1;
          else        in0_meta_ready_o = 1'b1;
          last_grant_d = ch_sel;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign proto_err_d = proto_err_q || (acc && sel_sop && !first_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      last_grant_q     <= 1'b1;
      first_q          <= 1'b1;
      proto_err_q      <= 1'b0;
      out_valid_q      <= 1'b0;
      out_meta_valid_q <= 1'b0;
      out_src_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      first_q          <= first_d;
      proto_err_q      <= proto_err_d;
      out_valid_q      <= acc;
      out_meta_valid_q <= acc_eop;
      if (acc) out_src_q <= ch_sel;
    end
  end

  // Payload registers are qualified by the valids and need no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      out_data_q  <= ch_sel ? in1_pkt_data_i  : in0_pkt_data_i;
      out_sop_q   <= sel_sop;
      out_eop_q   <= sel_eop;
      out_empty_q <= ch_sel ? in1_pkt_empty_i : in0_pkt_empty_i;
    end
    if (acc_eop) out_meta_q <= ch_sel ? in1_meta_data_i : in0_meta_data_i;
  end

  assign out_pkt_data_o    = out_data_q;
  assign out_pkt_valid_o   = out_valid_q;
  assign out_pkt_sop_o     = out_sop_q;
  assign out_pkt_eop_o     = out_eop_q;
  assign out_pkt_empty_o   = out_empty_q;
  assign out_meta_data_o   = out_meta_q;
  assign out_meta_valid_o  = out_meta_valid_q;
  assign out_src_channel_o = out_src_q;
  assign proto_err_o       = proto_err_q;

`ifdef TRAFFIC_MERGER_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc_eop && !ch_sel) cnt0_q <= cnt0_q + 1'b1;
      if (acc_eop &&  ch_sel) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign stat_pkt_cnt0_o = cnt0_q;
  assign stat_pkt_cnt1_o = cnt1_q;
`else
  assign stat_pkt_cnt0_o = '0;
  assign stat_pkt_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_traffic_merger.sv
// Directed testbench for traffic_merger. dut0 is round-robin, dut1 has channel-1 priority;
// both see the same stimulus, dut1 is only checked in the priority scenario.
module tb_traffic_merger;
  localparam int unsigned MW = 64;
  localparam int unsigned CW = 32;
`ifdef TRAFFIC_MERGER_STATS_EN
  localparam logic [CW-1:0] StatOne = 1;
`else
  localparam logic [CW-1:0] StatOne = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [511:0]  in0_data, in1_data;
  logic          in0_valid, in0_sop, in0_eop, in1_valid, in1_sop, in1_eop;
  logic [5:0]    in0_empty, in1_empty;
  logic [MW-1:0] in0_meta, in1_meta;
  logic          in0_mv, in1_mv, paf, maf;

  logic          r0, r1, mr0, mr1, o_valid, o_sop, o_eop, o_mv, o_src, o_perr;
  logic [511:0]  o_data;
  logic [5:0]    o_empty;
  logic [MW-1:0] o_meta;
  logic [CW-1:0] o_c0, o_c1;

  logic          p_r0, p_r1, p_mr0, p_mr1, p_valid, p_sop, p_eop, p_mv, p_src, p_perr;
  logic [511:0]  p_data;
  logic [5:0]    p_empty;
  logic [MW-1:0] p_meta;
  logic [CW-1:0] p_c0, p_c1;

  traffic_merger #(.PRIO_CH1(0), .CNT_WIDTH(CW), .META_WIDTH(MW)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in0_pkt_data_i(in0_data), .in0_pkt_valid_i(in0_valid), .in0_pkt_sop_i(in0_sop),
    .in0_pkt_eop_i(in0_eop), .in0_pkt_empty_i(in0_empty), .in0_pkt_ready_o(r0),
    .in0_meta_data_i(in0_meta), .in0_meta_valid_i(in0_mv), .in0_meta_ready_o(mr0),
    .in1_pkt_data_i(in1_data), .in1_pkt_valid_i(in1_valid), .in1_pkt_sop_i(in1_sop),
    .in1_pkt_eop_i(in1_eop), .in1_pkt_empty_i(in1_empty), .in1_pkt_ready_o(r1),
    .in1_meta_data_i(in1_meta), .in1_meta_valid_i(in1_mv), .in1_meta_ready_o(mr1),
    .out_pkt_data_o(o_data), .out_pkt_valid_o(o_valid), .out_pkt_sop_o(o_sop),
    .out_pkt_eop_o(o_eop), .out_pkt_empty_o(o_empty), .out_pkt_almost_full_i(paf),
    .out_meta_data_o(o_meta), .out_meta_valid_o(o_mv), .out_meta_almost_full_i(maf),
    .out_src_channel_o(o_src), .proto_err_o(o_perr),
    .stat_pkt_cnt0_o(o_c0), .stat_pkt_cnt1_o(o_c1)
  );

  traffic_merger #(.PRIO_CH1(1), .CNT_WIDTH(CW), .META_WIDTH(MW)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in0_pkt_data_i(in0_data), .in0_pkt_valid_i(in0_valid), .in0_pkt_sop_i(in0_sop),
    .in0_pkt_eop_i(in0_eop), .in0_pkt_empty_i(in0_empty), .in0_pkt_ready_o(p_r0),
    .in0_meta_data_i(in0_meta), .in0_meta_valid_i(in0_mv), .in0_meta_ready_o(p_mr0),
    .in1_pkt_data_i(in1_data), .in1_pkt_valid_i(in1_valid), .in1_pkt_sop_i(in1_sop),
    .in1_pkt_eop_i(in1_eop), .in1_pkt_empty_i(in1_empty), .in1_pkt_ready_o(p_r1),
    .in1_meta_data_i(in1_meta), .in1_meta_valid_i(in1_mv), .in1_meta_ready_o(p_mr1),
    .out_pkt_data_o(p_data), .out_pkt_valid_o(p_valid), .out_pkt_sop_o(p_sop),
    .out_pkt_eop_o(p_eop), .out_pkt_empty_o(p_empty), .out_pkt_almost_full_i(paf),
    .out_meta_data_o(p_meta), .out_meta_valid_o(p_mv), .out_meta_almost_full_i(maf),
    .out_src_channel_o(p_src), .proto_err_o(p_perr),
    .stat_pkt_cnt0_o(p_c0), .stat_pkt_cnt1_o(p_c1)
  );

  int tests  = 0;
  int failed = 0;
  int pops0  = 0;
  int pops1  = 0;
  int snap0;

  always @(posedge clk) begin
    if (mr0 && in0_mv) pops0++;
    if (mr1 && in1_mv) pops1++;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk(input logic [31:0] x);
    return {16{x}};
  endfunction

  initial begin
    rst_n = 1'b0;
    in0_data = '0; in0_valid = 0; in0_sop = 0; in0_eop = 0; in0_empty = '0; in0_meta = '0;
    in1_data = '0; in1_valid = 0; in1_sop = 0; in1_eop = 0; in1_empty = '0; in1_meta = '0;
    in0_mv = 0; in1_mv = 0; paf = 0; maf = 0;

    // Reset state
    #2;
    chk("rst_out_valid", o_valid, 0);
    chk("rst_meta_valid", o_mv, 0);
    chk("rst_src", o_src, 0);
    chk("rst_proto_err", o_perr, 0);
    chk("rst_rdy0", r0, 0);
    chk("rst_cnt0", o_c0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Ch0 only, 3-flit packet
    in0_data = mk(32'hA000_0000); in0_valid = 1; in0_sop = 1; in0_meta = 64'hA0A0_0001;
    in0_mv = 1; snap0 = pops0;
    #1 chk("t1_idle_rdy0", r0, 0);
    tick(); // grant
    chk("t1_rdy0", r0, 1);
    chk("t1_rdy1", r1, 0);
    chk("t1_grant_out_valid", o_valid, 0);
    tick(); // flit 0 accepted
    chk("t1_f0_valid", o_valid, 1);
    chk("t1_f0_data", o_data, mk(32'hA000_0000));
    chk("t1_f0_sop", o_sop, 1);
    chk("t1_f0_eop", o_eop, 0);
    chk("t1_f0_src", o_src, 0);
    chk("t1_f0_mv", o_mv, 0);
    in0_data = mk(32'hA000_0001); in0_sop = 0;
    tick();
    chk("t1_f1_data", o_data, mk(32'hA000_0001));
    chk("t1_f1_valid", o_valid, 1);
    in0_data = mk(32'hA000_0002); in0_eop = 1; in0_empty = 6'd5;
    #1 chk("t1_meta_ready", mr0, 1);
    tick();
    chk("t1_f2_data", o_data, mk(32'hA000_0002));
    chk("t1_f2_eop", o_eop, 1);
    chk("t1_f2_empty", o_empty, 6'd5);
    chk("t1_f2_mv", o_mv, 1);
    chk("t1_f2_meta", o_meta, 64'hA0A0_0001);
    chk("t1_f2_src", o_src, 0);
    in0_valid = 0; in0_mv = 0; in0_eop = 0; in0_empty = '0;
    tick();
    chk("t1_done_valid", o_valid, 0);
    chk("t1_done_mv", o_mv, 0);
    chk("t1_pops", pops0 - snap0, 1);

    // Both channels hold 1-flit packets: round-robin vs ch1 priority
    rst_n = 0; #1 rst_n = 1;
    in0_data = mk(32'hB000_0000); in0_valid = 1; in0_sop = 1; in0_eop = 1;
    in0_meta = 64'hB0; in0_mv = 1;
    in1_data = mk(32'hC000_0001); in1_valid = 1; in1_sop = 1; in1_eop = 1;
    in1_meta = 64'hC1; in1_mv = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t2_rr_valid_%0d", k), o_valid, (k % 2 == 0));
      chk($sformatf("t2_rr_mv_%0d", k), o_mv, (k % 2 == 0));
      chk($sformatf("t2_pr_valid_%0d", k), p_valid, (k % 2 == 0));
      chk($sformatf("t2_pr_rdy0_%0d", k), p_r0, 0);
      if (k % 2 == 0) begin
        chk($sformatf("t2_rr_src_%0d", k), o_src, (k % 4 == 0));
        chk($sformatf("t2_rr_data_%0d", k), o_data,
            (k % 4 == 0) ? mk(32'hC000_0001) : mk(32'hB000_0000));
        chk($sformatf("t2_pr_src_%0d", k), p_src, 1);
        chk($sformatf("t2_pr_data_%0d", k), p_data, mk(32'hC000_0001));
      end
    end
    in0_valid = 0; in0_mv = 0; in0_sop = 0; in0_eop = 0;
    in1_valid = 0; in1_mv = 0; in1_sop = 0; in1_eop = 0;
    tick(); tick();

    // Backpressure mid-packet on ch1, ch0 packet waiting
    in1_data = mk(32'hD000_0000); in1_valid = 1; in1_sop = 1; in1_meta = 64'hD1; in1_mv = 1;
    tick(); // grant ch1
    in0_data = mk(32'hE000_0000); in0_valid = 1; in0_sop = 1; in0_eop = 1;
    in0_meta = 64'hE0; in0_mv = 1;
    #1 chk("t3_rdy1", r1, 1);
    chk("t3_rdy0", r0, 0);
    tick();
    chk("t3_f0_data", o_data, mk(32'hD000_0000));
    chk("t3_f0_src", o_src, 1);
    in1_data = mk(32'hD000_0001); in1_sop = 0; paf = 1;
    #1 chk("t3_stall_rdy1", r1, 0);
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("t3_stall_valid_%0d", s), o_valid, 0);
      chk($sformatf("t3_stall_rdy1_%0d", s), r1, 0);
      chk($sformatf("t3_stall_rdy0_%0d", s), r0, 0);
    end
    paf = 0;
    #1 chk("t3_resume_rdy1", r1, 1);
    tick();
    chk("t3_f1_data", o_data, mk(32'hD000_0001));
    chk("t3_f1_src", o_src, 1);
    in1_data = mk(32'hD000_0002);
    tick();
    chk("t3_f2_data", o_data, mk(32'hD000_0002));
    chk("t3_f2_valid", o_valid, 1);
    in1_data = mk(32'hD000_0003); in1_eop = 1; in1_empty = 6'd3;
    #1 chk("t3_mr1", mr1, 1);
    chk("t3_mr0", mr0, 0);
    tick();
    chk("t3_f3_data", o_data, mk(32'hD000_0003));
    chk("t3_f3_eop", o_eop, 1);
    chk("t3_f3_empty", o_empty, 6'd3);
    chk("t3_f3_mv", o_mv, 1);
    chk("t3_f3_meta", o_meta, 64'hD1);
    chk("t3_f3_src", o_src, 1);
    in1_valid = 0; in1_mv = 0; in1_eop = 0;
    tick();
    chk("t3_bubble", o_valid, 0);
    tick();
    chk("t3_ch0_valid", o_valid, 1);
    chk("t3_ch0_data", o_data, mk(32'hE000_0000));
    chk("t3_ch0_src", o_src, 0);
    chk("t3_ch0_meta", o_meta, 64'hE0);
    in0_valid = 0; in0_mv = 0; in0_sop = 0; in0_eop = 0;
    tick();

    // Protocol error: sop repeated on the second flit of a 3-flit ch1 packet
    rst_n = 0; #1 rst_n = 1;
    in1_data = mk(32'hF000_0000); in1_valid = 1; in1_sop = 1; in1_meta = 64'hF1; in1_mv = 1;
    tick(); // grant
    tick();
    chk("t4_f0_data", o_data, mk(32'hF000_0000));
    chk("t4_f0_perr", o_perr, 0);
    in1_data = mk(32'hF000_0001); in1_sop = 1;
    tick();
    chk("t4_f1_data", o_data, mk(32'hF000_0001));
    chk("t4_f1_perr", o_perr, 1);
    in1_data = mk(32'hF000_0002); in1_sop = 0; in1_eop = 1;
    tick();
    chk("t4_f2_data", o_data, mk(32'hF000_0002));
    chk("t4_f2_mv", o_mv, 1);
    chk("t4_f2_meta", o_meta, 64'hF1);
    in1_valid = 0; in1_mv = 0; in1_eop = 0;
    tick(); tick();
    chk("t4_perr_sticky", o_perr, 1);
    chk("t4_cnt1", o_c1, StatOne);
    chk("t4_cnt0", o_c0, 0);

    // Reset mid-packet, then a fresh ch0 packet
    in0_data = mk(32'h6000_0000); in0_valid = 1; in0_sop = 1; in0_meta = 64'h60; in0_mv = 1;
    tick(); // grant
    tick();
    chk("t5_pre_valid", o_valid, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_valid", o_valid, 0);
    chk("t5_rst_perr", o_perr, 0);
    chk("t5_rst_rdy0", r0, 0);
    chk("t5_rst_cnt1", o_c1, 0);
    #2 rst_n = 1;
    in0_data = mk(32'h7000_0000); in0_eop = 1; in0_meta = 64'h70;
    tick(); // grant
    chk("t5_grant_valid", o_valid, 0);
    tick();
    chk("t5_valid", o_valid, 1);
    chk("t5_data", o_data, mk(32'h7000_0000));
    chk("t5_src", o_src, 0);
    chk("t5_mv", o_mv, 1);
    chk("t5_meta", o_meta, 64'h70);
    chk("t5_cnt0", o_c0, StatOne);
    in0_valid = 0; in0_mv = 0; in0_sop = 0; in0_eop = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/traffic_merger.md
Name: traffic_merger

Overview:
- Downstream counterpart of the traffic manager; merges its two output channels back into one packet-plus-metadata stream.
- Channel 0 carries packets with no rule-check path. Channel 1 carries packets that went through the rule-check path.
- Arbitration is packet-atomic: round-robin or strict channel-1 priority.
- Each forwarded packet is paired with exactly one metadata_t (from struct_s.sv) from the same channel.

Parameters:
- PRIO_CH1, 0: 0 = round-robin between channels; 1 = channel 1 always wins when both are eligible.
- CNT_WIDTH, 32: width of the per-channel packet counters (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in0_pkt_data/valid/sop/eop/empty  in  512/1/1/1/6  channel 0 packet stream
- in0_pkt_ready  out  1  channel 0 packet accept
- in0_meta_data  in  metadata_t  channel 0 metadata
- in0_meta_valid  in  1  channel 0 metadata valid
- in0_meta_ready  out  1  channel 0 metadata pop
- in1_pkt_data/valid/sop/eop/empty  in  512/1/1/1/6  channel 1 packet stream
- in1_pkt_ready  out  1  channel 1 packet accept
- in1_meta_data/valid  in  metadata_t/1  channel 1 metadata
- in1_meta_ready  out  1  channel 1 metadata pop
- out_pkt_data/valid/sop/eop/empty  out  512/1/1/1/6  merged packet stream
- out_pkt_almost_full  in  1  downstream packet FIFO backpressure
- out_meta_data  out  metadata_t  merged metadata
- out_meta_valid  out  1  merged metadata valid
- out_meta_almost_full  in  1  downstream metadata FIFO backpressure
- out_src_channel  out  1  source channel of the current output flit
- proto_err  out  1  sticky protocol-error flag
- stat_pkt_cnt0/1  out  CNT_WIDTH  per-channel forwarded packet counts (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = 1 (so channel 0 wins first under round-robin).
  - out_pkt_valid = 0, out_meta_valid = 0, out_src_channel = 0, proto_err = 0, counters = 0.
  - Data, sop, eop and empty registers are not reset; they are don't-care while the matching valid is low.
- Definitions:
  - naf = !out_pkt_almost_full & !out_meta_almost_full.
  - Channel i is eligible when naf & ini_meta_valid & ini_pkt_valid & ini_pkt_sop.
- State machine, states IDLE, CH0, CH1:
  - IDLE: with no channel eligible, stay in IDLE.
  - IDLE: with one channel eligible, go to that channel's state.
  - IDLE: with both eligible and PRIO_CH1=0, go to the channel != last_grant. With PRIO_CH1=1, go to CH1.
  - IDLE: both in*_pkt_ready are low, so the grant costs one cycle.
  - CHi: ini_pkt_ready = !out_pkt_almost_full; the other channel's ready is 0.
  - CHi: when a flit is accepted with eop (ini_pkt_valid & ini_pkt_ready & ini_pkt_eop), pulse ini_meta_ready for that cycle, set last_grant = i, and return to IDLE.
  - A single-flit packet (sop & eop) completes in one CHi cycle.
- Output timing:
  - Every accepted flit appears on out_pkt_* exactly 1 cycle later, with out_src_channel = i.
  - out_meta_valid pulses 1 cycle after the eop accept, aligned with out_pkt_eop. out_meta_data is the popped metadata.
  - No flits from the two channels are ever interleaved.
- Backpressure:
  - almost_full is sampled every cycle.
  - In CHi, assertion stalls acceptance mid-packet; the state is held and the packet resumes when almost_full drops.
  - Downstream FIFOs must provide at least 2 entries of slack after almost_full.
- Protocol error:
  - proto_err sets (sticky until reset) when, in CHi, a flit with sop is accepted that is not the packet's first flit.
  - The flit is still forwarded.
  - Metadata is never popped without an eop.
- Simultaneous events: eop completion and new eligibility in the same cycle do not chain. IDLE is always visited, so there is 1 bubble cycle per packet.
- Reset mid-packet: the FSM returns to IDLE, output valids drop immediately, and the partial packet is abandoned. Upstream is responsible for flushing it.

Optional Feature:
- Macro TRAFFIC_MERGER_STATS_EN.
- When defined: stat_pkt_cnt0/1 increment by 1 on each eop accept for their channel. They wrap modulo 2^CNT_WIDTH and reset to 0.
- When undefined: the counters are not instantiated and stat_pkt_cnt0/1 are tied to 0.

Test Plan:
- Ch0 only, 3-flit packet (sop on flit 0, eop on flit 2, empty=5), meta valid -> out flits at cycles g+2..g+4, where g is the IDLE grant cycle. out_meta_valid with eop, out_src_channel=0, in0_meta_ready pulses once.
- Both channels hold 1-flit packets continuously, PRIO_CH1=0 -> output order ch0, ch1, ch0, ch1, with 1 bubble between packets.
- Same stimulus with PRIO_CH1=1 -> only ch1 packets are forwarded; ch0 is starved, in0_pkt_ready stays 0.
- out_pkt_almost_full asserted for 4 cycles during flit 1 of a 4-flit ch1 packet -> no accepts during the stall, packet resumes intact, a ch0 packet waiting in parallel is not interleaved.
- Ch1 packet with a second sop on flit 2 of 3 -> proto_err=1 and stays 1; all 3 flits forwarded; with TRAFFIC_MERGER_STATS_EN, stat_pkt_cnt1 = 1.
- rst_n pulled low mid-packet -> outputs go low asynchronously; after release, a new ch0 packet is forwarded normally and counters restart from 0.
